memory_arbiter: RTL and testbench
=================================

Name: memory_arbiter

Overview:
- Responder side of the cache/hit interface consumed by the pipeline hazard logic.
- Accepts instruction-fetch and data-access requests from the datapath and serialises them onto the single-ported RAM.
- Returns registered one-cycle ihit/dhit pulses with load data; the hazard unit uses these to stall or advance pipeline stages.
- Data accesses have priority over fetches. Adds a wait-state timeout and sticky error.

Parameters:
- TIMEOUT, 64, max consecutive BUSY cycles in one access before entering ERR (must be >=2)
- WORD_W, 32, data/address width (matches word_t)

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  asynchronous, active-high reset
- iREN  in  1  instruction read request (level, held until ihit)
- iaddr  in  WORD_W  instruction address
- dREN  in  1  data read request (level)
- dWEN  in  1  data write request (level)
- daddr  in  WORD_W  data address
- dstore  in  WORD_W  write data
- halt  in  1  datapath halted; blocks new fetch grants
- ramstate  in  2  ramstate_t: FREE, BUSY, ACCESS, ERROR
- ramload  in  WORD_W  RAM read data, valid when ramstate==ACCESS
- ramREN  out  1  RAM read strobe
- ramWEN  out  1  RAM write strobe
- ramaddr  out  WORD_W  RAM address
- ramstore  out  WORD_W  RAM write data
- ihit  out  1  one-cycle fetch-complete pulse
- dhit  out  1  one-cycle data-complete pulse
- iload  out  WORD_W  fetched instruction, registered, held until next fetch completes
- dload  out  WORD_W  read data, registered, held until next data read completes
- err  out  1  sticky fault flag

Behaviour:
- Reset (async, RST=1): state IDLE; all outputs 0; latched address/data/op registers 0; wait counter 0. RST asserted mid-access aborts immediately; ramREN/ramWEN drop in the same cycle.
- States (arb_state_t): IDLE, IREQ, DREQ, IDONE, DDONE, ERR.
- IDLE
  - dREN|dWEN → DREQ; latch daddr, dstore, op (write if dWEN, else read). dWEN wins if both are set.
  - Else if iREN & !halt → IREQ; latch iaddr.
  - Else stay. No RAM strobes in IDLE.
- IREQ / DREQ
  - ramaddr/ramstore/ramREN/ramWEN driven from latched registers only. Mid-access changes on request ports are ignored.
  - ramstate==ACCESS → capture ramload into iload (IREQ) or dload (DREQ read). Go to IDONE / DDONE.
  - ramstate==ERROR → ERR.
  - Otherwise increment wait counter. At TIMEOUT consecutive non-ACCESS cycles → ERR.
  - Counter clears on every grant.
- IREQ abort: if iREN deasserts while in IREQ (branch/jump flush), return to IDLE next cycle with no ihit; iload unchanged. DREQ is never aborted.
- IDONE / DDONE
  - ihit (resp. dhit) = 1 for exactly this cycle; strobes low; next state IDLE.
  - This gives the requester one cycle to retire the request before IDLE re-samples it.
- ERR: err=1, strobes low, hits low. Held until RST.
- Latency: request sampled in IDLE at cycle t; strobes from t+1; ACCESS at cycle t+k (k>=1) → hit at t+k+1. Minimum request-to-hit is 2 cycles; minimum back-to-back period is 3 cycles.
- ihit and dhit are never both 1. Strobes never assert in IDLE, IDONE, DDONE or ERR.
- Simultaneous dREN and iREN in IDLE: data first. The fetch is granted after DDONE if still requested.
- halt=1 during IREQ does not abort the fetch; it only gates new fetch grants.
- Counter width: $clog2(TIMEOUT+1). Saturating, no wrap.

Decomposition:
- cpu_types_pkg:
  - Existing: word_t, ramstate_t.
  - New: arb_state_t enum, ARB_TIMEOUT_DEFAULT constant.
- Sub-module arb_wait_counter: clear, enable, and `expired` at TIMEOUT; saturating. Instantiated once.

Test Plan:
- Fetch only: iREN=1, iaddr=0x0000_0040, ramstate BUSY 2 cycles then ACCESS, ramload=0x8C01_0004 → ramREN=1 and ramaddr=0x40 from t+1; ihit=1 at t+4 only; iload=0x8C01_0004.
- Priority: iREN=1 and dWEN=1 in the same cycle, daddr=0x100, dstore=0xDEAD_BEEF, ACCESS immediately → ramWEN first with ramstore=0xDEADBEEF; dhit at t+2; fetch granted at t+3; ihit at t+5.
- Read/write conflict: dREN=1 and dWEN=1 together → write performed (ramWEN=1, ramREN=0); dload unchanged.
- Fetch abort: iREN drops 1 cycle into IREQ (ramstate BUSY) → IDLE next cycle; no ihit; iload retains its previous value.
- Timeout: TIMEOUT=4, dREN=1, ramstate stuck BUSY → ERR after 4 wait cycles; err=1 sticky; no dhit. RST=1 clears err asynchronously.
- Reset mid-access: RST pulsed while in DREQ with ramWEN=1 → ramWEN=0 in the same cycle; all outputs 0; state IDLE after release.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: word and RAM handshake encodings plus the arbiter FSM states.
package cpu_types_pkg;

   localparam int WORD_BITS = 32;
   localparam int ARB_TIMEOUT_DEFAULT = 64;

   typedef logic [WORD_BITS-1:0] word_t;

   typedef enum logic [1:0] {
      FREE   = 2'd0,
      BUSY   = 2'd1,
      ACCESS = 2'd2,
      ERROR  = 2'd3
   } ramstate_t;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      IREQ  = 3'd1,
      DREQ  = 3'd2,
      IDONE = 3'd3,
      DDONE = 3'd4,
      ERR   = 3'd5
   } arb_state_t;

endpackage

// File: rtl/arb_wait_counter.sv
// Saturating count of wait-state cycles within one RAM access; flags the cycle that
// would make the count reach TIMEOUT.
module arb_wait_counter
   import cpu_types_pkg::*;
#(
   parameter int TIMEOUT = ARB_TIMEOUT_DEFAULT
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clear_i,
   input  logic en_i,
   output logic expired_o
);

   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
   localparam logic [CW-1:0] MAX  = CW'(TIMEOUT);

   logic [CW-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (clear_i) begin
         count_d = '0;
      end else if (en_i && (count_q != MAX)) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   // Expiry is seen on the TIMEOUT-th wait cycle itself, so the FSM leaves right then.
   assign expired_o = en_i && !clear_i && (count_q >= LAST);

endmodule

// File: rtl/memory_arbiter.sv
// Serialises instruction fetches and data accesses onto a single-ported RAM and
// returns registered one-cycle ihit/dhit pulses; data wins over fetch.
module memory_arbiter
   import cpu_types_pkg::*;
#(
   parameter int TIMEOUT = ARB_TIMEOUT_DEFAULT,
   parameter int WORD_W  = WORD_BITS
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              iREN,
   input  logic [WORD_W-1:0] iaddr,
   input  logic              dREN,
   input  logic              dWEN,
   input  logic [WORD_W-1:0] daddr,
   input  logic [WORD_W-1:0] dstore,
   input  logic              halt,
   input  ramstate_t         ramstate,
   input  logic [WORD_W-1:0] ramload,
   output logic              ramREN,
   output logic              ramWEN,
   output logic [WORD_W-1:0] ramaddr,
   output logic [WORD_W-1:0] ramstore,
   output logic              ihit,
   output logic              dhit,
   output logic [WORD_W-1:0] iload,
   output logic [WORD_W-1:0] dload,
   output logic              err
);

   arb_state_t        state_q, state_d;
   logic [WORD_W-1:0] addr_q, addr_d;
   logic [WORD_W-1:0] store_q, store_d;
   logic [WORD_W-1:0] iload_q, iload_d;
   logic [WORD_W-1:0] dload_q, dload_d;
   logic              we_q, we_d;
   logic              in_req;
   logic              wait_expired;

   assign in_req = (state_q == IREQ) || (state_q == DREQ);

   // Counter is held clear outside an access, which clears it on every grant.
   arb_wait_counter #(.TIMEOUT(TIMEOUT)) u_wait (
      .clk_i     (CLK),
      .rst_i     (RST),
      .clear_i   (!in_req),
      .en_i      (in_req && (ramstate != ACCESS)),
      .expired_o (wait_expired)
   );

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      store_d = store_q;
      we_d    = we_q;
      iload_d = iload_q;
      dload_d = dload_q;
      unique case (state_q)
         IDLE: begin
            if (dREN || dWEN) begin
               state_d = DREQ;
               addr_d  = daddr;
               store_d = dstore;
               we_d    = dWEN;
            end else if (iREN && !halt) begin
               state_d = IREQ;
               addr_d  = iaddr;
               we_d    = 1'b0;
            end
         end
         IREQ: begin
            // A flushed fetch is dropped before a late ACCESS can complete it.
            if (ramstate == ERROR) begin
               state_d = ERR;
            end else if (!iREN) begin
               state_d = IDLE;
            end else if (ramstate == ACCESS) begin
               iload_d = ramload;
               state_d = IDONE;
            end else if (wait_expired) begin
               state_d = ERR;
            end
         end
         DREQ: begin
            if (ramstate == ERROR) begin
               state_d = ERR;
            end else if (ramstate == ACCESS) begin
               if (!we_q) begin
                  dload_d = ramload;
               end
               state_d = DDONE;
            end else if (wait_expired) begin
               state_d = ERR;
            end
         end
         IDONE:   state_d = IDLE;
         DDONE:   state_d = IDLE;
         ERR:     state_d = ERR;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= IDLE;
         addr_q  <= '0;
         store_q <= '0;
         we_q    <= 1'b0;
         iload_q <= '0;
         dload_q <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         store_q <= store_d;
         we_q    <= we_d;
         iload_q <= iload_d;
         dload_q <= dload_d;
      end
   end

   assign ramREN   = (state_q == IREQ) || ((state_q == DREQ) && !we_q);
   assign ramWEN   = (state_q == DREQ) && we_q;
   assign ramaddr  = addr_q;
   assign ramstore = store_q;
   assign ihit     = (state_q == IDONE);
   assign dhit     = (state_q == DDONE);
   assign err      = (state_q == ERR);
   assign iload    = iload_q;
   assign dload    = dload_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Random and directed traffic against memory_arbiter; a RAM responder, a reference
// memory and a hit scoreboard predict every access, hit cycle and load value.
`timescale 1ns/1ps
module tb_memory_arbiter;
   import cpu_types_pkg::*;

   localparam int TO = 4;
   localparam int W  = 32;

   typedef struct {
      int          busy;
      bit          inj_err;
      bit          we;
      logic [W-1:0] addr;
      logic [W-1:0] data;
   } acc_t;

   typedef struct {
      bit          is_d;
      logic [W-1:0] data;
      int          cyc;
   } exp_t;

   logic         CLK, RST, iREN, dREN, dWEN, halt;
   logic [W-1:0] iaddr, daddr, dstore, ramload;
   ramstate_t    ramstate;
   logic         ramREN, ramWEN, ihit, dhit, err;
   logic [W-1:0] ramaddr, ramstore, iload, dload;

   int total, bad, cyc;
   acc_t acc_q[$];
   exp_t exp_q[$];
   logic [W-1:0] ram_mem [logic [W-1:0]];
   logic [W-1:0] ref_mem [logic [W-1:0]];
   logic [W-1:0] last_i, last_d;

   memory_arbiter #(.TIMEOUT(TO), .WORD_W(W)) dut (
      .CLK(CLK), .RST(RST), .iREN(iREN), .iaddr(iaddr), .dREN(dREN), .dWEN(dWEN),
      .daddr(daddr), .dstore(dstore), .halt(halt), .ramstate(ramstate), .ramload(ramload),
      .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
      .ihit(ihit), .dhit(dhit), .iload(iload), .dload(dload), .err(err)
   );

   // ---------------- clock / reset ----------------
   initial CLK = 1'b0;
   always #5 CLK = ~CLK;
   initial cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   // ---------------- helpers ----------------
   function automatic logic [W-1:0] init_word(input logic [W-1:0] a);
      return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
   endfunction

   function automatic logic [W-1:0] ram_rd(input logic [W-1:0] a);
      if (ram_mem.exists(a)) return ram_mem[a];
      return init_word(a);
   endfunction

   function automatic logic [W-1:0] ref_rd(input logic [W-1:0] a);
      if (ref_mem.exists(a)) return ref_mem[a];
      return init_word(a);
   endfunction

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic reset_checks(input string tag);
      check({tag, "_ramREN"}, ramREN, 0);
      check({tag, "_ramWEN"}, ramWEN, 0);
      check({tag, "_ramaddr"}, ramaddr, 0);
      check({tag, "_ramstore"}, ramstore, 0);
      check({tag, "_ihit"}, ihit, 0);
      check({tag, "_dhit"}, dhit, 0);
      check({tag, "_iload"}, iload, 0);
      check({tag, "_dload"}, dload, 0);
      check({tag, "_err"}, err, 0);
   endtask

   // ---------------- RAM responder ----------------
   initial begin : responder
      acc_t cur;
      bit   in_acc;
      int   left;
      ramstate = FREE;
      ramload  = '0;
      in_acc   = 0;
      left     = 0;
      cur      = '{0, 1'b0, 1'b0, '0, '0};
      forever begin
         @(negedge CLK);
         if (ramREN || ramWEN) begin
            if (!in_acc) begin
               if (acc_q.size() == 0) begin
                  total++; bad++;
                  $display("FAIL ram_unexpected_access: ramREN=%b ramWEN=%b addr=%h with none pending",
                           ramREN, ramWEN, ramaddr);
                  cur = '{1000, 1'b0, ramWEN, ramaddr, ramstore};
               end else begin
                  cur = acc_q.pop_front();
               end
               in_acc = 1;
               left   = cur.busy;
            end
            check("ram_wen", ramWEN, cur.we);
            check("ram_ren", ramREN, !cur.we);
            check("ram_addr", ramaddr, cur.addr);
            if (cur.we) check("ram_store", ramstore, cur.data);
            if (cur.inj_err) begin
               ramstate = ERROR;
            end else if (left > 0) begin
               ramstate = BUSY;
               left--;
            end else begin
               ramstate = ACCESS;
               if (ramWEN) begin
                  ram_mem[ramaddr] = ramstore;
                  ramload = $urandom;
               end else begin
                  ramload = ram_rd(ramaddr);
               end
            end
         end else begin
            in_acc   = 0;
            ramstate = FREE;
         end
      end
   end

   // ---------------- hit monitor / scoreboard ----------------
   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge CLK);
         if (!RST && (ihit || dhit)) begin
            check("hit_exclusive", ihit & dhit, 0);
            if (exp_q.size() == 0) begin
               total++; bad++;
               $display("FAIL unexpected_hit: ihit=%b dhit=%b with no pending request", ihit, dhit);
            end else begin
               e = exp_q.pop_front();
               check("hit_kind_dhit", dhit, e.is_d);
               check("hit_cycle", cyc, e.cyc);
               if (e.is_d) check("dload", dload, e.data);
               else        check("iload", iload, e.data);
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic wait_hit(input bit want_d);
      for (int n = 0; n < 40; n++) begin
         @(negedge CLK);
         if (want_d ? dhit : ihit) return;
      end
      total++; bad++;
      $display("FAIL hit_timeout: no %s within 40 cycles", want_d ? "dhit" : "ihit");
   endtask

   task automatic gap();
      repeat ($urandom_range(1, 2)) @(negedge CLK);
   endtask

   task automatic do_fetch(input logic [W-1:0] a, input int busy);
      iREN  = 1'b1;
      iaddr = a;
      acc_q.push_back('{busy, 1'b0, 1'b0, a, '0});
      last_i = ref_rd(a);
      exp_q.push_back('{1'b0, last_i, cyc + busy + 2});
      @(negedge CLK);
      iaddr = $urandom;
      halt  = 1'($urandom_range(0, 1));
      wait_hit(1'b0);
      iREN = 1'b0;
      halt = 1'b0;
      gap();
   endtask

   task automatic do_data(input bit we, input bit conflict, input logic [W-1:0] a,
                          input logic [W-1:0] d, input int busy);
      logic [W-1:0] ed;
      dWEN   = we;
      dREN   = !we || conflict;
      daddr  = a;
      dstore = d;
      acc_q.push_back('{busy, 1'b0, we, a, d});
      if (we) begin
         ed = last_d;
         ref_mem[a] = d;
      end else begin
         last_d = ref_rd(a);
         ed = last_d;
      end
      exp_q.push_back('{1'b1, ed, cyc + busy + 2});
      @(negedge CLK);
      daddr  = $urandom;
      dstore = $urandom;
      wait_hit(1'b1);
      dREN = 1'b0;
      dWEN = 1'b0;
      gap();
   endtask

   task automatic do_both(input bit we, input logic [W-1:0] ia, input logic [W-1:0] da,
                          input logic [W-1:0] d, input int bd, input int bi);
      logic [W-1:0] ed;
      iREN = 1'b1; iaddr = ia;
      dWEN = we; dREN = !we; daddr = da; dstore = d;
      acc_q.push_back('{bd, 1'b0, we, da, d});
      acc_q.push_back('{bi, 1'b0, 1'b0, ia, '0});
      if (we) begin
         ed = last_d;
         ref_mem[da] = d;
      end else begin
         last_d = ref_rd(da);
         ed = last_d;
      end
      last_i = ref_rd(ia);
      exp_q.push_back('{1'b1, ed, cyc + bd + 2});
      exp_q.push_back('{1'b0, last_i, cyc + bd + bi + 5});
      wait_hit(1'b1);
      dREN = 1'b0;
      dWEN = 1'b0;
      wait_hit(1'b0);
      iREN = 1'b0;
      gap();
   endtask

   task automatic do_abort(input logic [W-1:0] a);
      iREN  = 1'b1;
      iaddr = a;
      acc_q.push_back('{20, 1'b0, 1'b0, a, '0});
      @(negedge CLK);
      iREN = 1'b0;
      @(negedge CLK);
      check("abort_ramREN", ramREN, 0);
      check("abort_iload", iload, last_i);
      gap();
   endtask

   task automatic do_halt_fetch(input logic [W-1:0] a, input int busy);
      halt  = 1'b1;
      iREN  = 1'b1;
      iaddr = a;
      repeat (3) @(negedge CLK);
      check("halt_no_grant", ramREN, 0);
      acc_q.push_back('{busy, 1'b0, 1'b0, a, '0});
      last_i = ref_rd(a);
      exp_q.push_back('{1'b0, last_i, cyc + busy + 2});
      halt = 1'b0;
      wait_hit(1'b0);
      iREN = 1'b0;
      gap();
   endtask

   task automatic pulse_reset(input string tag);
      #2 RST = 1'b1;
      #1 reset_checks(tag);
      last_i = '0;
      last_d = '0;
      iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0; halt = 1'b0;
      @(negedge CLK);
      RST = 1'b0;
      @(negedge CLK);
   endtask

   task automatic do_error(input bit inject, input logic [W-1:0] a);
      int lim;
      lim   = inject ? 1 : TO;
      dREN  = 1'b1;
      daddr = a;
      acc_q.push_back('{100, inject, 1'b0, a, '0});
      repeat (lim) @(negedge CLK);
      check(inject ? "ramerror_err_early" : "timeout_err_early", err, 0);
      @(negedge CLK);
      check(inject ? "ramerror_err" : "timeout_err", err, 1);
      dREN = 1'b0;
      repeat (3) @(negedge CLK);
      check("err_sticky", err, 1);
      check("err_strobes", {ramREN, ramWEN}, 0);
      pulse_reset(inject ? "rst_after_ramerror" : "rst_after_timeout");
   endtask

   task automatic do_reset_mid(input logic [W-1:0] a, input logic [W-1:0] d);
      dWEN   = 1'b1;
      daddr  = a;
      dstore = d;
      acc_q.push_back('{20, 1'b0, 1'b1, a, d});
      @(negedge CLK);
      check("rst_mid_pre_wen", ramWEN, 1);
      pulse_reset("rst_mid");
      check("rst_mid_after_wen", ramWEN, 0);
      check("rst_mid_after_ren", ramREN, 0);
      gap();
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #2_000_000;
      total++; bad++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // ---------------- main sequence ----------------
   initial begin
      int k;
      logic [W-1:0] a1, a2;
      total = 0; bad = 0;
      RST = 1'b1; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0; halt = 1'b0;
      iaddr = '0; daddr = '0; dstore = '0;
      last_i = '0; last_d = '0;
      ram_mem[32'h40] = 32'h8C01_0004;
      ref_mem[32'h40] = 32'h8C01_0004;
      repeat (2) @(negedge CLK);
      reset_checks("reset");
      RST = 1'b0;
      @(negedge CLK);

      do_fetch(32'h0000_0040, 2);
      do_both(1'b1, 32'h44, 32'h100, 32'hDEAD_BEEF, 0, 0);
      do_data(1'b1, 1'b1, 32'h104, 32'h1234_5678, 1);
      do_data(1'b0, 1'b0, 32'h100, '0, 0);
      do_abort(32'h80);
      do_halt_fetch(32'h48, 1);
      do_data(1'b0, 1'b1, 32'h104, 32'hFFFF_0000, 0);
      do_error(1'b0, 32'h10);
      do_error(1'b1, 32'h14);
      do_reset_mid(32'h108, 32'hCAFE_F00D);

      for (int t = 0; t < 150; t++) begin
         k  = $urandom_range(0, 9);
         a1 = 32'($urandom_range(0, 15)) << 2;
         a2 = 32'h100 + (32'($urandom_range(0, 7)) << 2);
         case (k)
            0, 1, 2: do_fetch(a1, $urandom_range(0, 3));
            3, 4:    do_data(1'b0, 1'b0, ($urandom_range(0, 1) != 0) ? a1 : a2, '0, $urandom_range(0, 3));
            5, 6:    do_data(1'b1, 1'b0, ($urandom_range(0, 1) != 0) ? a1 : a2, $urandom, $urandom_range(0, 3));
            7:       do_data(1'b1, 1'b1, a2, $urandom, $urandom_range(0, 2));
            8:       do_both(1'($urandom_range(0, 1)), a1, a2, $urandom,
                             $urandom_range(0, 2), $urandom_range(0, 2));
            default: begin
               if ($urandom_range(0, 1) != 0) do_abort(a1);
               else do_halt_fetch(a1, $urandom_range(0, 2));
            end
         endcase
      end

      repeat (4) @(negedge CLK);
      check("exp_q_drained", exp_q.size(), 0);
      check("acc_q_drained", acc_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
